// File: rtl/braille_pkg.sv
// Shared constants for the Braille cell to 7-segment path: dots->ASCII map,
// hex->segment patterns (active-high, a in the MSB) and the blank pattern.
package braille_pkg;

  localparam logic [6:0] SEG_BLANK = 7'b0000000;

  // Indexed by the dot vector read as a number, dot 1 in the MSB and dot 6 in the LSB.
  localparam logic [7:0] DOTS_TO_ASCII [64] = '{
    8'h20, 8'h2C, 8'h22, 8'h3B, 8'h40, 8'h2E, 8'h5E, 8'h5F,
    8'h27, 8'h2D, 8'h39, 8'h30, 8'h2F, 8'h2B, 8'h3E, 8'h23,
    8'h31, 8'h35, 8'h33, 8'h34, 8'h49, 8'h5B, 8'h4A, 8'h57,
    8'h32, 8'h38, 8'h36, 8'h37, 8'h53, 8'h21, 8'h54, 8'h29,
    8'h41, 8'h2A, 8'h45, 8'h3A, 8'h43, 8'h25, 8'h44, 8'h3F,
    8'h4B, 8'h55, 8'h4F, 8'h5A, 8'h4D, 8'h58, 8'h4E, 8'h59,
    8'h42, 8'h3C, 8'h48, 8'h5C, 8'h46, 8'h24, 8'h47, 8'h5D,
    8'h4C, 8'h56, 8'h52, 8'h28, 8'h50, 8'h26, 8'h51, 8'h3D
  };

  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

endpackage

// File: rtl/hex_to_7seg.sv
// Combinational nibble to 7-segment pattern, segments a..g on [1..7].
// Macro SEG_ACTIVE_LOW_EN inverts the pattern for common-anode displays.
module hex_to_7seg
  import braille_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [1:7] seg
);

`ifdef SEG_ACTIVE_LOW_EN
  assign seg = ~HEX_SEG[nibble];
`else
  assign seg = HEX_SEG[nibble];
`endif

endmodule

// File: rtl/braille_to_7seg.sv
// Registered Braille cell (dots 1..6) to two-digit hex ASCII 7-segment display.
// Macro SEG_ACTIVE_LOW_EN selects active-low segments (blank = all ones).
module braille_to_7seg
  import braille_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic [1:6] i,
  output logic [1:7] o1,
  output logic [1:7] o0
);

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [1:7] SEG_OFF = ~SEG_BLANK;
`else
  localparam logic [1:7] SEG_OFF = SEG_BLANK;
`endif

  logic [7:0] code;
  logic [1:7] seg_next [2];
  logic [1:7] o1_reg;
  logic [1:7] o0_reg;

  // i is packed with dot 1 as MSB, which is exactly the table's index order.
  assign code = DOTS_TO_ASCII[i];

  // Digit 0 renders the low nibble, digit 1 the high nibble.
  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_digit
      hex_to_7seg u_hex (
        .nibble (code[4*gi +: 4]),
        .seg    (seg_next[gi])
      );
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      o1_reg <= SEG_OFF;
      o0_reg <= SEG_OFF;
    end else begin
      o1_reg <= seg_next[1];
      o0_reg <= seg_next[0];
    end
  end

  assign o1 = o1_reg;
  assign o0 = o0_reg;

endmodule

// File: tb/tb_braille_to_7seg.sv
// Directed bench for braille_to_7seg: reset, table samples, full sweep with mid-stream reset.
// Honours SEG_ACTIVE_LOW_EN by inverting all expected patterns.
module tb_braille_to_7seg;

  logic       clk = 1'b0;
  logic       rst;
  logic [1:6] i;
  logic [1:7] o1;
  logic [1:7] o0;

  int checks = 0;
  int errors = 0;

`ifdef SEG_ACTIVE_LOW_EN
  localparam logic [6:0] POL = 7'h7F;
`else
  localparam logic [6:0] POL = 7'h00;
`endif
  localparam logic [13:0] BLANK = {POL, POL};

  // Dot patterns (dot 1 = MSB) for codes 0x20..0x5F, transcribed from the character table.
  localparam logic [5:0] CODE_DOTS [64] = '{
    6'd0,  6'd29, 6'd2,  6'd15, 6'd53, 6'd37, 6'd61, 6'd8,
    6'd59, 6'd31, 6'd33, 6'd13, 6'd1,  6'd9,  6'd5,  6'd12,
    6'd11, 6'd16, 6'd24, 6'd18, 6'd19, 6'd17, 6'd26, 6'd27,
    6'd25, 6'd10, 6'd35, 6'd3,  6'd49, 6'd63, 6'd14, 6'd39,
    6'd4,  6'd32, 6'd48, 6'd36, 6'd38, 6'd34, 6'd52, 6'd54,
    6'd50, 6'd20, 6'd22, 6'd40, 6'd56, 6'd44, 6'd46, 6'd42,
    6'd60, 6'd62, 6'd58, 6'd28, 6'd30, 6'd41, 6'd57, 6'd23,
    6'd45, 6'd47, 6'd43, 6'd21, 6'd51, 6'd55, 6'd6,  6'd7
  };

  logic [7:0] exp_code [64];
  bit         seen [256];

  braille_to_7seg dut (
    .clk (clk),
    .rst (rst),
    .i   (i),
    .o1  (o1),
    .o0  (o0)
  );

  always #5 clk = ~clk;

  function automatic logic [6:0] ref_seg(input logic [3:0] n);
    case (n)
      4'h0: return 7'b1111110;  4'h1: return 7'b0110000;
      4'h2: return 7'b1101101;  4'h3: return 7'b1111001;
      4'h4: return 7'b0110011;  4'h5: return 7'b1011011;
      4'h6: return 7'b1011111;  4'h7: return 7'b1110000;
      4'h8: return 7'b1111111;  4'h9: return 7'b1111011;
      4'hA: return 7'b1110111;  4'hB: return 7'b0011111;
      4'hC: return 7'b1001110;  4'hD: return 7'b0111101;
      4'hE: return 7'b1001111;  default: return 7'b1000111;
    endcase
  endfunction

  function automatic logic [13:0] ref_pair(input logic [7:0] c);
    return {ref_seg(c[7:4]) ^ POL, ref_seg(c[3:0]) ^ POL};
  endfunction

  function automatic int unseg(input logic [6:0] s);
    for (int n = 0; n < 16; n++)
      if ((ref_seg(4'(n)) ^ POL) === s) return n;
    return -1;
  endfunction

  task automatic check_eq(input string tag, input logic [13:0] got, input logic [13:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%b_%b exp=%b_%b", tag, got[13:7], got[6:0], exp[13:7], exp[6:0]);
    end else begin
      $display("ok   %s o1=%b o0=%b", tag, got[13:7], got[6:0]);
    end
  endtask

  task automatic step(input logic r, input logic [5:0] d);
    @(negedge clk);
    rst = r;
    i   = d;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int hi, lo, distinct;
    for (int k = 0; k < 64; k++) exp_code[CODE_DOTS[k]] = 8'h20 + 8'(k);
    for (int k = 0; k < 256; k++) seen[k] = 1'b0;

    rst = 1'b1;
    i   = 6'b101010;
    step(1'b1, 6'b101010);
    check_eq("reset_c1", {o1, o0}, BLANK);
    step(1'b1, 6'b101010);
    check_eq("reset_c2", {o1, o0}, BLANK);

    step(1'b0, 6'b000000);
    check_eq("space_20", {o1, o0}, {7'b1101101, 7'b1111110} ^ BLANK);
    step(1'b0, 6'b100000);
    check_eq("A_41", {o1, o0}, {7'b0110011, 7'b0110000} ^ BLANK);
    step(1'b0, 6'b101011);
    check_eq("Z_5A", {o1, o0}, {7'b1011011, 7'b1110111} ^ BLANK);
    step(1'b0, 6'b111111);
    check_eq("eq_3D", {o1, o0}, {7'b1111001, 7'b0111101} ^ BLANK);
    step(1'b0, 6'b000101);
    check_eq("dot_2E", {o1, o0}, {7'b1101101, 7'b1001111} ^ BLANK);

    for (int d = 0; d < 64; d++) begin
      if (d == 40) begin
        step(1'b1, 6'(d));
        check_eq("mid_reset", {o1, o0}, BLANK);
      end
      step(1'b0, 6'(d));
      check_eq($sformatf("sweep_%0d", d), {o1, o0}, ref_pair(exp_code[d]));
      hi = unseg(o1);
      lo = unseg(o0);
      if (hi >= 0 && lo >= 0) seen[hi * 16 + lo] = 1'b1;
    end

    distinct = 0;
    for (int c = 8'h20; c <= 8'h5F; c++) if (seen[c]) distinct++;
    check_eq("distinct_codes", 14'(distinct), 14'd64);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
